countdown_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 12 +
 rtl/zero_flag.sv | 11 +
 rtl/countdown_timer.sv | 78 +++++++
 tb/tb_countdown_timer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer slice.
package timer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/zero_flag.sv
// All-zero detector: NOR reduction of a WIDTH-bit bus.
module zero_flag #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  assign zero = ~|value;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, busy flag and a one-cycle done pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic             next_zero;

  // The output flag watches the registered count.
  zero_flag #(.WIDTH(WIDTH)) u_zero_count (
    .value (count),
    .zero  (zero)
  );

  // The same detector on the upcoming count decides RUN vs DONE, so a load of 0
  // and the final decrement both land in DONE without a separate compare.
  zero_flag #(.WIDTH(WIDTH)) u_zero_next (
    .value (count_next),
    .zero  (next_zero)
  );

  // Next count: start loads, otherwise decrement in RUN unless paused.
  always_comb begin
    count_next = count;
    if (start) begin
      count_next = load_val;
    end else if (state == RUN && !pause) begin
      count_next = count - ONE;
    end
  end

  // Next state: start has priority over pause and decrement.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = next_zero ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (start || !pause) state_next = next_zero ? DONE : RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, count and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] load_val;
  logic       pause;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       zero;

  int total;
  int bad;

  countdown_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_val (load_val),
    .pause    (pause),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; load_val = 8'd0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
        bad++;
        $display("FAIL reset_state[%0d]: count=%0d busy=%b done=%b zero=%b want 0/0/0/1", i, count, busy, done, zero);
      end
      step();
    end
  endtask

  task automatic test_load5();
    start = 1'b1; load_val = 8'd5;
    step();
    start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      total++;
      if (count !== 8'(5 - j) || busy !== 1'b1 || done !== 1'b0 || zero !== 1'b0) begin
        bad++;
        $display("FAIL load5_run[%0d]: count=%0d busy=%b done=%b zero=%b want %0d/1/0/0", j, count, busy, done, zero, 5 - j);
      end
      step();
    end
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b1 || zero !== 1'b1) begin
      bad++;
      $display("FAIL load5_done: count=%0d busy=%b done=%b zero=%b want 0/0/1/1", count, busy, done, zero);
    end
    step();
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL load5_idle: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_load0();
    start = 1'b1; load_val = 8'd0;
    step();
    start = 1'b0;
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL load0_done: count=%0d busy=%b done=%b want 0/0/1", count, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL load0_after[%0d]: count=%0d busy=%b done=%b want 0/0/0", i, count, busy, done);
      end
    end
  endtask

  task automatic test_pause();
    start = 1'b1; load_val = 8'd4;
    step();
    start = 1'b0;
    step(); step();
    total++;
    if (count !== 8'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pause_pre: count=%0d busy=%b want 2/1", count, busy);
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (count !== 8'd2 || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL pause_hold[%0d]: count=%0d busy=%b done=%b want 2/1/0", i, count, busy, done);
      end
    end
    pause = 1'b0;
    step();
    total++;
    if (count !== 8'd1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL pause_resume: count=%0d busy=%b done=%b want 1/1/0", count, busy, done);
    end
    step();
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL pause_done_at7: count=%0d busy=%b done=%b want 0/0/1", count, busy, done);
    end
    step();
  endtask

  task automatic test_restart();
    start = 1'b1; load_val = 8'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (count !== 8'd6) begin
      bad++;
      $display("FAIL restart_pre: count=%0d want 6", count);
    end
    start = 1'b1; load_val = 8'd3; pause = 1'b1;
    step();
    start = 1'b0; pause = 1'b0;
    total++;
    if (count !== 8'd3 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart_load: count=%0d busy=%b done=%b want 3/1/0", count, busy, done);
    end
    step(); step();
    total++;
    if (count !== 8'd1 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart_mid: count=%0d done=%b want 1/0", count, done);
    end
    step();
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL restart_done: count=%0d busy=%b done=%b want 0/0/1", count, busy, done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; load_val = 8'd8;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (count !== 8'd4 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: count=%0d busy=%b want 4/1", count, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_state: count=%0d busy=%b done=%b zero=%b want 0/0/0/1", count, busy, done, zero);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
        bad++;
        $display("FAIL rstmid_nodone[%0d]: count=%0d busy=%b done=%b want 0/0/0", i, count, busy, done);
      end
    end
  endtask

  task automatic test_load255();
    start = 1'b1; load_val = 8'd255;
    step();
    start = 1'b0;
    for (int j = 0; j < 255; j++) begin
      total++;
      if (count !== 8'(255 - j) || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL load255_run[%0d]: count=%0d busy=%b done=%b want %0d/1/0", j, count, busy, done, 255 - j);
      end
      step();
    end
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b1 || zero !== 1'b1) begin
      bad++;
      $display("FAIL load255_done: count=%0d busy=%b done=%b zero=%b want 0/0/1/1", count, busy, done, zero);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL load255_nowrap[%0d]: count=%0d busy=%b done=%b want 0/0/0", i, count, busy, done);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; start = 1'b0; pause = 1'b0; load_val = 8'd0;
    test_reset();
    test_load5();
    test_load0();
    test_pause();
    test_restart();
    test_reset_mid();
    test_load255();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
